// File: rtl/riscv_isa_pkg.sv
// Shared R5P core types used by the GPR write-port arbiter.
// wbu_t     : source that owns the register-file write port in a given cycle.
// warb_st_t : state of the write-port arbiter starvation FSM.
package riscv_isa_pkg;

    localparam int unsigned GPR_AW = 5;                 // GPR address width
    localparam int unsigned GPR_N  = 32;                // number of GPRs
    localparam int unsigned WCNT_W = 4;                 // wait counter width, covers WAIT_MAX up to 15

    // Write-port owner for the current cycle
    typedef enum logic [1:0] {
        WBU_NONE = 2'd0,
        WBU_PIP  = 2'd1,
        WBU_MDU  = 2'd2
    } wbu_t;

    // Arbiter FSM state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } warb_st_t;

endpackage

// File: rtl/r5p_gpr_scb.sv
// Pending-destination scoreboard for in-flight MDU results.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   set_vld, set_adr  mark a destination pending (issue)
//   clr_vld, clr_adr  release a destination (accepted result)
//   rs1, rs2, rd      decoder addresses for the hazard lookup
//   pend              registered scoreboard, bit 0 always 0
//   hzd               any looked-up address is pending
module r5p_gpr_scb
    import riscv_isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_vld,
    input  logic [GPR_AW-1:0] set_adr,
    input  logic              clr_vld,
    input  logic [GPR_AW-1:0] clr_adr,
    input  logic [GPR_AW-1:0] rs1,
    input  logic [GPR_AW-1:0] rs2,
    input  logic [GPR_AW-1:0] rd,
    output logic [GPR_N-1:0]  pend,
    output logic              hzd
);

    logic [GPR_N-1:0] set_msk;
    logic [GPR_N-1:0] clr_msk;
    logic [GPR_N-1:0] pend_nxt;

    // Set is applied after clear so a same-address collision leaves the bit set
    always_comb begin
        set_msk  = set_vld ? (GPR_N'(1) << set_adr) : '0;
        clr_msk  = clr_vld ? (GPR_N'(1) << clr_adr) : '0;
        pend_nxt = ((pend & ~clr_msk) | set_msk) & ~GPR_N'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Lookup uses the registered state only; x0 can never hit since bit 0 stays 0
    always_comb begin
        hzd = pend[rs1] | pend[rs2] | pend[rd];
    end

endmodule

// File: rtl/r5p_gpr_warb.sv
// GPR write-port arbiter and MDU result scheduler.
// The pipeline write-back has priority; the MDU takes the port when it is free,
// when its result targets x0, or after WAIT_MAX blocked cycles via a one-cycle
// FORCE that stalls the pipeline write.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   pip_wen/adr/dat, pip_stl   write-back request and stall (re-present when stalled)
//   mdu_vld/adr/dat, mdu_rdy   MDU result handshake
//   iss_vld, iss_rd            MDU issue, marks destination pending
//   dec_rs1/rs2/rd, dec_hzd    decode hazard lookup
//   gpr_wen/adr/dat            registered register-file write port
//   pend                       pending-destination scoreboard
module r5p_gpr_warb
    import riscv_isa_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WAIT_MAX = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              pip_wen,
    input  logic [GPR_AW-1:0] pip_adr,
    input  logic [XLEN-1:0]   pip_dat,
    output logic              pip_stl,
    input  logic              mdu_vld,
    input  logic [GPR_AW-1:0] mdu_adr,
    input  logic [XLEN-1:0]   mdu_dat,
    output logic              mdu_rdy,
    input  logic              iss_vld,
    input  logic [GPR_AW-1:0] iss_rd,
    input  logic [GPR_AW-1:0] dec_rs1,
    input  logic [GPR_AW-1:0] dec_rs2,
    input  logic [GPR_AW-1:0] dec_rd,
    output logic              dec_hzd,
    output logic              gpr_wen,
    output logic [GPR_AW-1:0] gpr_adr,
    output logic [XLEN-1:0]   gpr_dat,
    output logic [GPR_N-1:0]  pend
);

    warb_st_t          st;
    logic [WCNT_W-1:0] cnt;
    logic              port_busy;
    logic              mdu_x0;
    logic              blocked;
    logic              scb_set;
    logic              scb_clr;
    wbu_t              win;

    // Grant decode; a pipeline write to x0 leaves the port free
    always_comb begin
        port_busy = pip_wen && (pip_adr != '0);
        mdu_x0    = (mdu_adr == '0);
        mdu_rdy   = mdu_vld && (!port_busy || (st == FORCE) || mdu_x0);
        pip_stl   = (st == FORCE);
        blocked   = mdu_vld && !mdu_rdy;
        scb_set   = iss_vld && (iss_rd != '0);
        scb_clr   = mdu_rdy && !mdu_x0;
        win       = WBU_NONE;
        if (scb_clr) begin
            win = WBU_MDU;
        end else if (port_busy && !pip_stl) begin
            win = WBU_PIP;
        end
    end

    // Starvation FSM: count blocked cycles, then force one MDU grant
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (blocked) begin
                        st  <= WAIT;
                        cnt <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mdu_rdy) begin
                        st  <= IDLE;
                        cnt <= '0;
                    end else if (cnt == WCNT_W'(WAIT_MAX)) begin
                        st <= FORCE;
                    end else begin
                        cnt <= cnt + WCNT_W'(1);
                    end
                end
                FORCE: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
                default: begin
                    st  <= IDLE;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Registered write port; address/data hold when nothing wins
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_wen <= 1'b0;
            gpr_adr <= '0;
            gpr_dat <= '0;
        end else begin
            gpr_wen <= (win != WBU_NONE);
            case (win)
                WBU_MDU: begin
                    gpr_adr <= mdu_adr;
                    gpr_dat <= mdu_dat;
                end
                WBU_PIP: begin
                    gpr_adr <= pip_adr;
                    gpr_dat <= pip_dat;
                end
                default: begin
                end
            endcase
        end
    end

    r5p_gpr_scb u_scb (
        .clk     (clk),
        .rst     (rst),
        .set_vld (scb_set),
        .set_adr (iss_rd),
        .clr_vld (scb_clr),
        .clr_adr (mdu_adr),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .pend    (pend),
        .hzd     (dec_hzd)
    );

    // MDU must hold its result while waiting for the port
    a_mdu_hold: assert property (@(posedge clk) disable iff (rst)
        (st == WAIT) |-> mdu_vld);

    // Issue to a pending rd is only legal when that rd is being released this cycle
    a_iss_pend: assert property (@(posedge clk) disable iff (rst)
        scb_set |-> (!pend[iss_rd] || (scb_clr && (mdu_adr == iss_rd))));

endmodule

// File: tb/tb_r5p_gpr_warb.sv
// Directed bench for r5p_gpr_warb: expected register-file writes are queued when
// stimulus is driven and popped when the DUT presents gpr_wen.
module tb_r5p_gpr_warb;

    logic        clk = 1'b0;
    logic        rst;
    logic        pip_wen;
    logic [4:0]  pip_adr;
    logic [31:0] pip_dat;
    logic        pip_stl;
    logic        mdu_vld;
    logic [4:0]  mdu_adr;
    logic [31:0] mdu_dat;
    logic        mdu_rdy;
    logic        iss_vld;
    logic [4:0]  iss_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_hzd;
    logic        gpr_wen;
    logic [4:0]  gpr_adr;
    logic [31:0] gpr_dat;
    logic [31:0] pend;

    int          errors = 0;
    int          checks = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_w;

    always #5 clk = ~clk;

    r5p_gpr_warb #(.XLEN(32), .WAIT_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .pip_wen (pip_wen),
        .pip_adr (pip_adr),
        .pip_dat (pip_dat),
        .pip_stl (pip_stl),
        .mdu_vld (mdu_vld),
        .mdu_adr (mdu_adr),
        .mdu_dat (mdu_dat),
        .mdu_rdy (mdu_rdy),
        .iss_vld (iss_vld),
        .iss_rd  (iss_rd),
        .dec_rs1 (dec_rs1),
        .dec_rs2 (dec_rs2),
        .dec_rd  (dec_rd),
        .dec_hzd (dec_hzd),
        .gpr_wen (gpr_wen),
        .gpr_adr (gpr_adr),
        .gpr_dat (gpr_dat),
        .pend    (pend)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pip_wen = 1'b0; pip_adr = '0; pip_dat = '0;
        mdu_vld = 1'b0; mdu_adr = '0; mdu_dat = '0;
        iss_vld = 1'b0; iss_rd  = '0;
        dec_rs1 = '0;   dec_rs2 = '0; dec_rd  = '0;
    endtask

    // Every write the DUT makes must be the oldest expected one
    always @(negedge clk) begin
        if (gpr_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", gpr_adr, gpr_dat);
            end else begin
                exp_w = exp_q.pop_front();
                chk("gpr_write", 64'({gpr_adr, gpr_dat}), 64'(exp_w));
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();

        // Reset, port busy: MDU blocked, nothing pending, no write
        pip_wen = 1'b1; pip_adr = 5'd3; pip_dat = 32'h3333_0000;
        mdu_vld = 1'b1; mdu_adr = 5'd6; mdu_dat = 32'h6666_0000;
        iss_vld = 1'b1; iss_rd  = 5'd6; dec_rs1 = 5'd6;
        @(negedge clk);
        chk("rst_rdy_busy", 64'(mdu_rdy), 64'd0);
        chk("rst_stl",      64'(pip_stl), 64'd0);
        chk("rst_pend",     64'(pend),    64'd0);
        chk("rst_wen",      64'(gpr_wen), 64'd0);
        tick();

        // Reset, port free: MDU would be accepted
        pip_wen = 1'b0; iss_rd = 5'd7; mdu_dat = 32'h1234_5678;
        @(negedge clk);
        chk("rst_rdy_free", 64'(mdu_rdy), 64'd1);
        chk("rst_hzd",      64'(dec_hzd), 64'd0);
        tick();
        rst = 1'b0;
        idle();
        chk("rst_gpr_wen", 64'(gpr_wen), 64'd0);
        chk("rst_gpr_adr", 64'(gpr_adr), 64'd0);
        chk("rst_gpr_dat", 64'(gpr_dat), 64'd0);
        chk("rst_pend2",   64'(pend),    64'd0);

        // Free port: MDU result accepted same cycle, written next cycle
        iss_vld = 1'b1; iss_rd = 5'd5;
        tick();
        iss_vld = 1'b0;
        chk("iss_x5_pend", 64'(pend), 64'h20);
        mdu_vld = 1'b1; mdu_adr = 5'd5; mdu_dat = 32'hDEAD_BEEF;
        push(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("free_rdy",      64'(mdu_rdy), 64'd1);
        chk("free_stl",      64'(pip_stl), 64'd0);
        chk("free_pend_hld", 64'(pend),    64'h20);
        tick();
        mdu_vld = 1'b0;
        chk("free_wen", 64'(gpr_wen), 64'd1);
        chk("free_adr", 64'(gpr_adr), 64'd5);
        chk("free_dat", 64'(gpr_dat), 64'hDEAD_BEEF);
        chk("free_pend_clr", 64'(pend), 64'd0);

        // Pending x11 and x9 for the wait scenarios
        iss_vld = 1'b1; iss_rd = 5'd11;
        tick();
        iss_rd = 5'd9;
        tick();
        iss_vld = 1'b0;
        chk("iss_pend_2", 64'(pend), 64'h0000_0A00);

        // Short wait: blocked two cycles, then granted when the port frees
        pip_wen = 1'b1; pip_adr = 5'd8; pip_dat = 32'h88;
        mdu_vld = 1'b1; mdu_adr = 5'd11; mdu_dat = 32'hB1;
        for (int i = 0; i < 2; i++) begin
            push(5'd8, 32'h88);
            @(negedge clk);
            chk("wait_blk_rdy", 64'(mdu_rdy), 64'd0);
            tick();
        end
        pip_wen = 1'b0;
        push(5'd11, 32'hB1);
        @(negedge clk);
        chk("wait_free_rdy", 64'(mdu_rdy), 64'd1);
        tick();
        mdu_vld = 1'b0;

        // Starvation: five blocked cycles, then FORCE grants the MDU
        pip_wen = 1'b1; pip_adr = 5'd7; pip_dat = 32'h77;
        mdu_vld = 1'b1; mdu_adr = 5'd9; mdu_dat = 32'h99;
        for (int i = 0; i < 5; i++) begin
            push(5'd7, 32'h77);
            @(negedge clk);
            chk("starve_rdy", 64'(mdu_rdy), 64'd0);
            chk("starve_stl", 64'(pip_stl), 64'd0);
            tick();
        end
        push(5'd9, 32'h99);
        @(negedge clk);
        chk("force_stl", 64'(pip_stl), 64'd1);
        chk("force_rdy", 64'(mdu_rdy), 64'd1);
        tick();
        mdu_vld = 1'b0;
        chk("force_adr", 64'(gpr_adr), 64'd9);
        push(5'd7, 32'h77);
        @(negedge clk);
        chk("post_force_stl", 64'(pip_stl), 64'd0);
        tick();
        pip_wen = 1'b0;
        chk("post_force_adr", 64'(gpr_adr), 64'd7);
        chk("starve_pend", 64'(pend), 64'd0);

        // Hazard lookup against registered scoreboard
        iss_vld = 1'b1; iss_rd = 5'd3;
        tick();
        iss_vld = 1'b0;
        dec_rs2 = 5'd3;
        @(negedge clk);
        chk("hzd_rs2", 64'(dec_hzd), 64'd1);
        dec_rs2 = 5'd0;
        #1;
        chk("hzd_x0", 64'(dec_hzd), 64'd0);
        dec_rd = 5'd3;
        #1;
        chk("hzd_rd", 64'(dec_hzd), 64'd1);
        dec_rd = 5'd0; dec_rs1 = 5'd3;
        tick();
        mdu_vld = 1'b1; mdu_adr = 5'd3; mdu_dat = 32'h33;
        push(5'd3, 32'h33);
        @(negedge clk);
        chk("hzd_acc_rdy", 64'(mdu_rdy), 64'd1);
        chk("hzd_no_byp",  64'(dec_hzd), 64'd1);
        tick();
        mdu_vld = 1'b0;
        chk("hzd_clr", 64'(dec_hzd), 64'd0);
        dec_rs1 = 5'd0;

        // Same-cycle set and clear of x4: set wins
        iss_vld = 1'b1; iss_rd = 5'd4;
        tick();
        mdu_vld = 1'b1; mdu_adr = 5'd4; mdu_dat = 32'h44;
        push(5'd4, 32'h44);
        @(negedge clk);
        chk("setclr_rdy", 64'(mdu_rdy), 64'd1);
        tick();
        mdu_vld = 1'b0; iss_vld = 1'b0;
        chk("setclr_pend", 64'(pend), 64'h10);
        mdu_vld = 1'b1; mdu_dat = 32'h45;
        push(5'd4, 32'h45);
        tick();
        mdu_vld = 1'b0;
        chk("setclr_pend2", 64'(pend), 64'd0);

        // x0 MDU result accepted while the pipeline writes x2
        pip_wen = 1'b1; pip_adr = 5'd2; pip_dat = 32'h22;
        mdu_vld = 1'b1; mdu_adr = 5'd0; mdu_dat = 32'hBAD;
        push(5'd2, 32'h22);
        @(negedge clk);
        chk("x0_rdy", 64'(mdu_rdy), 64'd1);
        chk("x0_stl", 64'(pip_stl), 64'd0);
        tick();
        chk("x0_adr", 64'(gpr_adr), 64'd2);
        chk("x0_dat", 64'(gpr_dat), 64'h22);

        // Pipeline write to x0 leaves the port free for the MDU
        pip_adr = 5'd0; pip_dat = 32'h1;
        mdu_adr = 5'd10; mdu_dat = 32'hAA;
        push(5'd10, 32'hAA);
        @(negedge clk);
        chk("pip_x0_rdy", 64'(mdu_rdy), 64'd1);
        tick();
        idle();
        tick();
        tick();

        // No winner: write enable drops, address and data hold
        chk("hold_wen", 64'(gpr_wen), 64'd0);
        chk("hold_adr", 64'(gpr_adr), 64'd10);
        chk("hold_dat", 64'(gpr_dat), 64'hAA);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
